data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/mem_pkg.sv | 29 ++
 rtl/mem_lane_align.sv | 80 ++++++++
 rtl/data_mem_responder.sv | 148 ++++++++++++++
 tb/tb_data_mem_responder.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared types and defaults for the data memory responder.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_pkg;

    typedef enum logic [2:0] {
        DM_BS = 3'b000,
        DM_HS = 3'b001,
        DM_W  = 3'b010,
        DM_BU = 3'b100,
        DM_HU = 3'b101
    } dm_ctrl_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dm_state_e;

    localparam int unsigned C_DEPTH_WORDS = 1024;
    localparam int unsigned C_LATENCY     = 2;

endpackage

`default_nettype wire

// File: rtl/mem_lane_align.sv
// ============================================================================
//  Module      : mem_lane_align
//  Description : Byte-lane steering, load extension and store byte enables.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_lane_align
    import mem_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  ctrl,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [31:0] wword,
    output logic [3:0]  be,
    output logic [31:0] rdata,
    output logic        err
);

    logic       w_legal;
    logic       w_misalign;
    logic [7:0] w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_legal    = 1'b0;
        w_misalign = 1'b0;
        w_byte     = 8'h00;
        w_half     = 16'h0000;
        wword      = wdata;
        be         = 4'b0000;
        rdata      = 32'h0000_0000;

        case (ctrl)
            DM_BS, DM_HS, DM_W: w_legal = 1'b1;
            DM_BU, DM_HU:       w_legal = !we;
            default:            w_legal = 1'b0;
        endcase

        w_misalign = ((ctrl[1:0] == 2'b01) && addr_lo[0]) ||
                     ((ctrl[1:0] == 2'b10) && (addr_lo != 2'b00));
        err = !w_legal || w_misalign;

        case (addr_lo)
            2'd0:    w_byte = rword[7:0];
            2'd1:    w_byte = rword[15:8];
            2'd2:    w_byte = rword[23:16];
            default: w_byte = rword[31:24];
        endcase
        w_half = addr_lo[1] ? rword[31:16] : rword[15:0];

        // Store data is replicated across lanes so the enables alone pick the target.
        case (ctrl[1:0])
            2'b00:   wword = {4{wdata[7:0]}};
            2'b01:   wword = {2{wdata[15:0]}};
            default: wword = wdata;
        endcase

        if (we && !err) begin
            case (ctrl[1:0])
                2'b00:   be = 4'b0001 << addr_lo;
                2'b01:   be = addr_lo[1] ? 4'b1100 : 4'b0011;
                default: be = 4'b1111;
            endcase
        end

        if (!we && !err) begin
            case (ctrl[1:0])
                2'b00:   rdata = ctrl[2] ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
                2'b01:   rdata = ctrl[2] ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
                default: rdata = rword;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/data_mem_responder.sv
// ============================================================================
//  Module      : data_mem_responder
//  Description : Single-outstanding load/store responder with fixed latency.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module data_mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = C_DEPTH_WORDS,
    parameter int unsigned LATENCY     = C_LATENCY
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_ctrl,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned c_idx_w  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  c_lat_m1 = 4'(LATENCY - 1);
    localparam logic [31:0] c_depth  = 32'(DEPTH_WORDS);

    dm_state_e          r_state;
    dm_state_e          w_state_next;
    logic [3:0]         r_cnt;
    logic               r_we;
    logic [2:0]         r_ctrl;
    logic [31:0]        r_addr;
    logic [31:0]        r_wdata;
    logic [31:0]        r_rdata;
    logic               r_err;
    logic [31:0]        r_mem [0:DEPTH_WORDS-1];

    logic               w_accept;
    logic               w_enter_resp;
    logic               w_cur_we;
    logic [2:0]         w_cur_ctrl;
    logic [31:0]        w_cur_addr;
    logic [31:0]        w_cur_wdata;
    logic [c_idx_w-1:0] w_idx;
    logic               w_range_err;
    logic               w_lane_err;
    logic               w_err;
    logic [31:0]        w_wword;
    logic [3:0]         w_be;
    logic [31:0]        w_load;

    assign req_ready  = (r_state == ST_IDLE);
    assign resp_valid = (r_state == ST_RESP);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;
    assign w_accept   = req_valid && req_ready;

    // With LATENCY=1 the response is formed on the accept edge itself, before
    // the request has been latched, so the live inputs are used while idle.
    assign w_cur_we    = (r_state == ST_IDLE) ? req_we    : r_we;
    assign w_cur_ctrl  = (r_state == ST_IDLE) ? req_ctrl  : r_ctrl;
    assign w_cur_addr  = (r_state == ST_IDLE) ? req_addr  : r_addr;
    assign w_cur_wdata = (r_state == ST_IDLE) ? req_wdata : r_wdata;

    assign w_idx       = w_cur_addr[c_idx_w+1:2];
    assign w_range_err = ({2'b00, w_cur_addr[31:2]} >= c_depth);
    assign w_err       = w_lane_err || w_range_err;

    mem_lane_align u_lane_align (
        .we      (w_cur_we),
        .ctrl    (w_cur_ctrl),
        .addr_lo (w_cur_addr[1:0]),
        .wdata   (w_cur_wdata),
        .rword   (r_mem[w_idx]),
        .wword   (w_wword),
        .be      (w_be),
        .rdata   (w_load),
        .err     (w_lane_err)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_next = (LATENCY == 1) ? ST_RESP : ST_WAIT;
            ST_WAIT: if (r_cnt == 4'd1) w_state_next = ST_RESP;
            ST_RESP: if (resp_ready) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
        w_enter_resp = (w_state_next == ST_RESP) && (r_state != ST_RESP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_ctrl  <= 3'b000;
            r_addr  <= 32'h0;
            r_wdata <= 32'h0;
            r_rdata <= 32'h0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cnt   <= c_lat_m1;
                r_we    <= req_we;
                r_ctrl  <= req_ctrl;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
            end else if (r_state == ST_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end

            if (w_enter_resp) begin
                r_rdata <= w_err ? 32'h0 : w_load;
                r_err   <= w_err;
            end else if ((r_state == ST_RESP) && resp_ready) begin
                r_rdata <= 32'h0;
                r_err   <= 1'b0;
            end
        end
    end

    // Storage is deliberately outside reset; a reset on the commit edge blocks the write.
    always_ff @(posedge clk) begin
        if (!rst && w_enter_resp && !w_err) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wword[8*i +: 8];
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
// ============================================================================
//  Module      : tb_data_mem_responder
//  Description : Scoreboard bench for data_mem_responder directed scenarios.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_data_mem_responder;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned LAT   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_ctrl = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_err;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    exp_t        exp_q[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          hs_cyc = 0;
    logic        chk_b2b = 1'b0;

    data_mem_responder #(
        .DEPTH_WORDS (DEPTH),
        .LATENCY     (LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_ctrl   (req_ctrl),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    task automatic issue(input logic we, input logic [2:0] ctrl, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata,
                         input logic exp_err);
        int n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout actual=req_ready_low required=req_ready_high");
            return;
        end
        req_valid = 1'b1;
        req_we    = we;
        req_ctrl  = ctrl;
        req_addr  = addr;
        req_wdata = wdata;
        exp_q.push_back('{exp_rdata, exp_err, cyc});
        @(negedge clk);
        // Junk on the idle bus must not disturb the outstanding request.
        req_valid = 1'b0;
        req_we    = 1'b1;
        req_ctrl  = 3'b111;
        req_addr  = 32'hFFFF_FFFC;
        req_wdata = 32'hA5A5_A5A5;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d_pending required=0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor samples one time unit before each rising edge.
    initial begin : monitor
        logic        prev_valid = 1'b0;
        logic        prev_hs    = 1'b0;
        logic [31:0] prev_rdata = 32'h0;
        logic        prev_err   = 1'b0;
        exp_t        e;
        forever begin
            @(negedge clk);
            #4;
            if (rst) begin
                prev_valid = 1'b0;
                prev_hs    = 1'b0;
            end else begin
                if (resp_valid && !prev_valid) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_resp actual=resp_valid required=no_response");
                    end else begin
                        check("latency", 32'(cyc - exp_q[0].acc), 32'(LAT));
                    end
                end
                if (resp_valid && prev_valid && !prev_hs) begin
                    check("stable_rdata", resp_rdata, prev_rdata);
                    check("stable_err", {31'h0, resp_err}, {31'h0, prev_err});
                    check("stall_req_ready", {31'h0, req_ready}, 32'h0);
                end
                if (resp_valid && resp_ready && exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("resp_rdata", resp_rdata, e.rdata);
                    check("resp_err", {31'h0, resp_err}, {31'h0, e.err});
                    hs_cyc = cyc;
                end
                if (req_valid && req_ready && chk_b2b) begin
                    check("accept_after_hs", 32'(cyc), 32'(hs_cyc + 1));
                    chk_b2b = 1'b0;
                end
                prev_valid = resp_valid;
                prev_hs    = resp_valid && resp_ready;
                prev_rdata = resp_rdata;
                prev_err   = resp_err;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        repeat (3) @(negedge clk);
        check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rst_req_ready", {31'h0, req_ready}, 32'h1);
        check("rst_rdata", resp_rdata, 32'h0);
        check("rst_err", {31'h0, resp_err}, 32'h0);
        rst = 1'b0;

        issue(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0);
        issue(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);
        issue(1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFF_FFDE, 1'b0);
        issue(1'b0, 3'b100, 32'h13, 32'h0, 32'h0000_00DE, 1'b0);
        issue(1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF_DEAD, 1'b0);
        issue(1'b0, 3'b101, 32'h10, 32'h0, 32'h0000_BEEF, 1'b0);
        issue(1'b1, 3'b000, 32'h11, 32'h1234_5677, 32'h0, 1'b0);
        issue(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD_77EF, 1'b0);

        issue(1'b0, 3'b010, 32'h12, 32'h0, 32'h0, 1'b1);
        issue(1'b0, 3'b001, 32'h11, 32'h0, 32'h0, 1'b1);
        issue(1'b0, 3'b010, 32'(4 * DEPTH), 32'h0, 32'h0, 1'b1);
        issue(1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1);
        issue(1'b1, 3'b100, 32'h10, 32'h0000_0000, 32'h0, 1'b1);
        issue(1'b1, 3'b010, 32'h11, 32'h0000_0000, 32'h0, 1'b1);
        issue(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD_77EF, 1'b0);

        issue(1'b1, 3'b001, 32'h12, 32'hAAAA_1234, 32'h0, 1'b0);
        issue(1'b0, 3'b001, 32'h12, 32'h0, 32'h0000_1234, 1'b0);
        issue(1'b0, 3'b010, 32'h10, 32'h0, 32'h1234_77EF, 1'b0);
        drain();

        // Stalled response, then a request waiting to go the moment it completes.
        resp_ready = 1'b0;
        issue(1'b0, 3'b000, 32'h10, 32'h0, 32'hFFFF_FFEF, 1'b0);
        repeat (7) @(negedge clk);
        resp_ready = 1'b1;
        chk_b2b    = 1'b1;
        issue(1'b0, 3'b101, 32'h12, 32'h0, 32'h0000_1234, 1'b0);
        drain();

        // Store abandoned by reset while waiting.
        issue(1'b1, 3'b010, 32'h20, 32'h0, 32'h0, 1'b0);
        drain();
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_ctrl  = 3'b010;
        req_addr  = 32'h20;
        req_wdata = 32'h1;
        @(negedge clk);
        req_valid = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("post_rst_req_ready", {31'h0, req_ready}, 32'h1);
        check("post_rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("post_rst_rdata", resp_rdata, 32'h0);
        repeat (3) @(negedge clk);
        check("abandoned_no_resp", {31'h0, resp_valid}, 32'h0);
        issue(1'b0, 3'b010, 32'h20, 32'h0, 32'h0, 1'b0);
        drain();

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
